pcie_tx_mrd_arb: RTL and testbench

- Arbitrates PCIe memory-read (MRd) requests from two sources into the single MRd request port of the PCIe TX engine.
  - Source 0: PRP-list fetch requests (tx_prp_mrd_*) from the DMA command block.
  - Source 1: host-data reads for TX DMA.
- Uses round-robin selection with a registered request hold stage.
- Enforces a per-source limit on outstanding reads that have not yet completed.
- Sits between the DMA command / TX DMA engines and the TLP transmit path, in the pcie_user_clk domain.

---
 rtl/pcie_tx_mrd_arb_pkg.sv | 19 +
 rtl/pcie_tx_mrd_arb_cnt.sv | 40 ++++
 rtl/pcie_tx_mrd_arb.sv | 123 ++++++++++++
 tb/tb_pcie_tx_mrd_arb.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_tx_mrd_arb_pkg.sv
// Shared definitions for the two-source PCIe MRd request arbiter.
package pcie_tx_mrd_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  localparam logic SRC_PRP  = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam int MRD_TAG_W = 8;
  localparam int MRD_LEN_W = 11;

  function automatic int cnt_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/pcie_tx_mrd_arb_cnt.sv
// Outstanding-read counter for one source: +1 per grant, -1 per completed read,
// with a sticky flag when a completion arrives while nothing is outstanding.
module mrd_outstanding_cnt #(
  parameter int C_MAX_OUTSTANDING = 8,
  parameter int L_CNT_WIDTH       = 4
) (
  input  logic pcie_user_clk,
  input  logic pcie_user_rst,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_at_limit,
  output logic o_underflow
);

  localparam logic [L_CNT_WIDTH-1:0] L_MAX = L_CNT_WIDTH'(C_MAX_OUTSTANDING);

  logic [L_CNT_WIDTH-1:0] r_cnt;
  logic                   r_underflow;

  always_ff @(posedge pcie_user_clk) begin
    if (pcie_user_rst) begin
      r_cnt       <= '0;
      r_underflow <= 1'b0;
    end else begin
      case ({i_inc, i_dec})
        2'b10:   r_cnt <= r_cnt + L_CNT_WIDTH'(1);
        2'b01: begin
          // a completion with nothing outstanding is an upstream bug: flag it, hold at 0
          if (r_cnt == '0) r_underflow <= 1'b1;
          else             r_cnt       <= r_cnt - L_CNT_WIDTH'(1);
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_at_limit  = (r_cnt >= L_MAX);
  assign o_underflow = r_underflow;

endmodule

// File: rtl/pcie_tx_mrd_arb.sv
// Round-robin arbiter of PRP-fetch and TX-data MRd requests onto the TLP engine
// request port, with a per-source cap on reads awaiting completion.
module pcie_tx_mrd_arb
  import pcie_tx_mrd_arb_pkg::*;
#(
  parameter int C_PCIE_ADDR_WIDTH = 48,
  parameter int C_MAX_OUTSTANDING = 8
) (
  input  logic                         pcie_user_clk,
  input  logic                         pcie_user_rst,
  input  logic                         prp_mrd_req,
  input  logic [MRD_TAG_W-1:0]         prp_mrd_tag,
  input  logic [12:2]                  prp_mrd_len,
  input  logic [C_PCIE_ADDR_WIDTH-1:2] prp_mrd_addr,
  output logic                         prp_mrd_req_ack,
  input  logic                         data_mrd_req,
  input  logic [MRD_TAG_W-1:0]         data_mrd_tag,
  input  logic [12:2]                  data_mrd_len,
  input  logic [C_PCIE_ADDR_WIDTH-1:2] data_mrd_addr,
  output logic                         data_mrd_req_ack,
  input  logic                         prp_cpl_done,
  input  logic                         data_cpl_done,
  output logic                         tx_mrd_req,
  output logic [MRD_TAG_W-1:0]         tx_mrd_tag,
  output logic [12:2]                  tx_mrd_len,
  output logic [C_PCIE_ADDR_WIDTH-1:2] tx_mrd_addr,
  input  logic                         tx_mrd_req_ack,
  output logic                         cnt_underflow_err
);

  localparam int L_CNT_WIDTH = cnt_width(C_MAX_OUTSTANDING);

  state_t                       r_state;
  logic                         r_last_grant;
  logic                         r_tx_req;
  logic [MRD_TAG_W-1:0]         r_tag;
  logic [12:2]                  r_len;
  logic [C_PCIE_ADDR_WIDTH-1:2] r_addr;
  logic                         r_prp_ack;
  logic                         r_data_ack;

  logic [1:0] w_req, w_dec, w_elig, w_inc, w_at_limit, w_underflow;
  logic       w_grant, w_win;

  assign w_req  = {data_mrd_req, prp_mrd_req};
  assign w_dec  = {data_cpl_done, prp_cpl_done};
  assign w_elig = w_req & ~w_at_limit;

  // on a tie the source not served last wins; otherwise whichever is eligible
  assign w_win   = (&w_elig) ? ~r_last_grant : w_elig[SRC_DATA];
  assign w_grant = (r_state == ST_IDLE) && (|w_elig);
  assign w_inc[SRC_PRP]  = w_grant && (w_win == SRC_PRP);
  assign w_inc[SRC_DATA] = w_grant && (w_win == SRC_DATA);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      mrd_outstanding_cnt #(
        .C_MAX_OUTSTANDING(C_MAX_OUTSTANDING),
        .L_CNT_WIDTH      (L_CNT_WIDTH)
      ) u_cnt (
        .pcie_user_clk(pcie_user_clk),
        .pcie_user_rst(pcie_user_rst),
        .i_inc        (w_inc[gi]),
        .i_dec        (w_dec[gi]),
        .o_at_limit   (w_at_limit[gi]),
        .o_underflow  (w_underflow[gi])
      );
    end
  endgenerate

  always_ff @(posedge pcie_user_clk) begin
    if (pcie_user_rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= SRC_DATA;
      r_tx_req     <= 1'b0;
      r_tag        <= '0;
      r_len        <= '0;
      r_addr       <= '0;
      r_prp_ack    <= 1'b0;
      r_data_ack   <= 1'b0;
    end else begin
      r_prp_ack  <= 1'b0;
      r_data_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state      <= ST_ISSUE;
            r_tx_req     <= 1'b1;
            r_last_grant <= w_win;
            if (w_win == SRC_DATA) begin
              r_tag      <= data_mrd_tag;
              r_len      <= data_mrd_len;
              r_addr     <= data_mrd_addr;
              r_data_ack <= 1'b1;
            end else begin
              r_tag     <= prp_mrd_tag;
              r_len     <= prp_mrd_len;
              r_addr    <= prp_mrd_addr;
              r_prp_ack <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          // staying here at least one cycle lets the served source drop req
          if (tx_mrd_req_ack) begin
            r_tx_req <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign prp_mrd_req_ack   = r_prp_ack;
  assign data_mrd_req_ack  = r_data_ack;
  assign tx_mrd_req        = r_tx_req;
  assign tx_mrd_tag        = r_tag;
  assign tx_mrd_len        = r_len;
  assign tx_mrd_addr       = r_addr;
  assign cnt_underflow_err = |w_underflow;

endmodule

// File: tb/tb_pcie_tx_mrd_arb.sv
// Self-checking bench for pcie_tx_mrd_arb: directed vector table, hand-written
// hold/reset sequences, then randomized traffic against a transaction-level model.
module tb_pcie_tx_mrd_arb;

  localparam int AW   = 48;
  localparam int MAXO = 2;

  localparam logic [7:0]  PRP_TAG  = 8'h05;
  localparam logic [10:0] PRP_LEN  = 11'h010;
  localparam logic [45:0] PRP_ADDR = 46'h1000;
  localparam logic [7:0]  DAT_TAG  = 8'h22;
  localparam logic [10:0] DAT_LEN  = 11'h080;
  localparam logic [45:0] DAT_ADDR = 46'h2000;

  logic          clk = 1'b0;
  logic          rst;
  logic          prp_req, data_req, prp_ack, data_ack;
  logic [7:0]    prp_tag, data_tag, tx_tag;
  logic [12:2]   prp_len, data_len, tx_len;
  logic [AW-1:2] prp_addr, data_addr, tx_addr;
  logic          prp_cpl, data_cpl, tx_req, tx_ack, uf_err;

  always #5 clk = ~clk;

  pcie_tx_mrd_arb #(.C_PCIE_ADDR_WIDTH(AW), .C_MAX_OUTSTANDING(MAXO)) dut (
    .pcie_user_clk    (clk),
    .pcie_user_rst    (rst),
    .prp_mrd_req      (prp_req),
    .prp_mrd_tag      (prp_tag),
    .prp_mrd_len      (prp_len),
    .prp_mrd_addr     (prp_addr),
    .prp_mrd_req_ack  (prp_ack),
    .data_mrd_req     (data_req),
    .data_mrd_tag     (data_tag),
    .data_mrd_len     (data_len),
    .data_mrd_addr    (data_addr),
    .data_mrd_req_ack (data_ack),
    .prp_cpl_done     (prp_cpl),
    .data_cpl_done    (data_cpl),
    .tx_mrd_req       (tx_req),
    .tx_mrd_tag       (tx_tag),
    .tx_mrd_len       (tx_len),
    .tx_mrd_addr      (tx_addr),
    .tx_mrd_req_ack   (tx_ack),
    .cnt_underflow_err(uf_err)
  );

  typedef logic [68:0] obs_t;

  typedef struct {
    logic r0, r1, c0, c1, ta;
    logic a0, a1, tr, uf;
    int   fs;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl[$];

  // model state for the random phase
  int          m_busy, m_last, m_uf, m_tx_req;
  int          m_cnt[2];
  int          m_ack[2];
  logic [7:0]  m_tag;
  logic [10:0] m_len;
  logic [45:0] m_addr;
  logic        s_req[2];
  int          s_hold[2];
  logic [7:0]  s_tag[2];
  logic [10:0] s_len[2];
  logic [45:0] s_addr[2];

  function automatic obs_t dut_obs();
    return {prp_ack, data_ack, tx_req, tx_tag, tx_len, tx_addr, uf_err};
  endfunction

  function automatic obs_t exp_obs(logic a0, logic a1, logic tr, logic uf, int fs);
    logic [7:0]  t;
    logic [10:0] l;
    logic [45:0] a;
    t = '0; l = '0; a = '0;
    if (fs == 0) begin t = PRP_TAG; l = PRP_LEN; a = PRP_ADDR; end
    else if (fs == 1) begin t = DAT_TAG; l = DAT_LEN; a = DAT_ADDR; end
    return {a0, a1, tr, t, l, a, uf};
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {ack0,ack1,req,tag,len,addr,uf}=%h required %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r0, input logic r1, input logic c0, input logic c1,
                        input logic ta);
    prp_req  = r0;  data_req = r1;
    prp_cpl  = c0;  data_cpl = c1;
    tx_ack   = ta;
    prp_tag  = PRP_TAG; prp_len  = PRP_LEN; prp_addr  = PRP_ADDR;
    data_tag = DAT_TAG; data_len = DAT_LEN; data_addr = DAT_ADDR;
  endtask

  // expected outputs after one clock edge, from the arbitration rules as plain arithmetic
  task automatic model_step(input logic c0, input logic c1, input logic ta);
    int g;
    int d;
    logic [1:0] cpl;
    cpl = {c1, c0};
    g = -1;
    if (m_busy == 0) begin
      if (s_req[0] && m_cnt[0] < MAXO && s_req[1] && m_cnt[1] < MAXO) g = 1 - m_last;
      else if (s_req[0] && m_cnt[0] < MAXO) g = 0;
      else if (s_req[1] && m_cnt[1] < MAXO) g = 1;
    end
    m_ack[0] = 0;
    m_ack[1] = 0;
    if (g >= 0) begin
      m_busy = 1; m_tx_req = 1; m_ack[g] = 1; m_last = g;
      m_tag = s_tag[g]; m_len = s_len[g]; m_addr = s_addr[g];
    end else if (m_busy != 0 && ta) begin
      m_busy = 0; m_tx_req = 0;
    end
    for (int s = 0; s < 2; s++) begin
      d = ((s == g) ? 1 : 0) - (cpl[s] ? 1 : 0);
      if (d < 0 && m_cnt[s] == 0) m_uf = 1;
      else m_cnt[s] += d;
    end
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0);
    tick();
    tick();
    check("reset", dut_obs(), '0);

    //             r0 r1 c0 c1 ta  a0 a1 tr uf fs
    tbl.push_back('{1, 0, 0, 0, 0,  1, 0, 1, 0, 0});  // single PRP grant at t+1
    tbl.push_back('{1, 0, 0, 0, 0,  0, 0, 1, 0, 0});  // req held one cycle past ack
    tbl.push_back('{0, 0, 0, 0, 1,  0, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 0,  0, 1, 1, 0, 1});  // tie goes to DATA after PRP
    tbl.push_back('{1, 0, 0, 0, 1,  0, 0, 0, 0, 1});
    tbl.push_back('{1, 0, 0, 0, 0,  1, 0, 1, 0, 0});  // PRP reaches limit of 2
    tbl.push_back('{0, 0, 0, 0, 1,  0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0,  0, 0, 0, 0, 0});  // third PRP stalls
    tbl.push_back('{1, 0, 1, 0, 0,  0, 0, 0, 0, 0});  // completion frees a slot
    tbl.push_back('{1, 0, 0, 0, 0,  1, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 1,  0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 1, 0, 0,  1, 0, 1, 0, 0});  // grant + completion together
    tbl.push_back('{0, 0, 1, 0, 1,  0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 0,  0, 0, 0, 1, 0});  // completion at count 0
    tbl.push_back('{0, 0, 0, 1, 0,  0, 0, 0, 1, 0});
    tbl.push_back('{1, 1, 0, 0, 0,  0, 1, 1, 1, 1});
    tbl.push_back('{1, 0, 0, 0, 0,  0, 0, 1, 1, 1});
    tbl.push_back('{1, 0, 0, 0, 1,  0, 0, 0, 1, 1});
    tbl.push_back('{1, 0, 0, 0, 0,  1, 0, 1, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 1,  0, 0, 0, 1, 0});

    rst = 1'b0;
    foreach (tbl[i]) begin
      set_in(tbl[i].r0, tbl[i].r1, tbl[i].c0, tbl[i].c1, tbl[i].ta);
      tick();
      check($sformatf("vec%0d", i), dut_obs(),
            exp_obs(tbl[i].a0, tbl[i].a1, tbl[i].tr, tbl[i].uf, tbl[i].fs));
      $display("vec %0d: req=%b%b cpl=%b%b txack=%b -> ack=%b%b tx_req=%b uf=%b",
               i, tbl[i].r0, tbl[i].r1, tbl[i].c0, tbl[i].c1, tbl[i].ta,
               prp_ack, data_ack, tx_req, uf_err);
    end

    // TLP engine stalls a PRP issue for 20 cycles while DATA waits
    set_in(1, 0, 0, 0, 0);
    tick();
    check("hold_grant", dut_obs(), exp_obs(1, 0, 1, 1, 0));
    for (int k = 0; k < 20; k++) begin
      set_in(0, 1, 0, 0, 0);
      tick();
      check($sformatf("hold%0d", k), dut_obs(), exp_obs(0, 0, 1, 1, 0));
    end
    set_in(0, 1, 0, 0, 1);
    tick();
    check("hold_release", dut_obs(), exp_obs(0, 0, 0, 1, 0));
    set_in(0, 1, 0, 0, 0);
    tick();
    check("hold_data_grant", dut_obs(), exp_obs(0, 1, 1, 1, 1));
    $display("hold sequence: DATA granted after PRP issue released");

    // reset during ISSUE drops it and clears counters (DATA was at its limit)
    set_in(0, 1, 0, 0, 0);
    rst = 1'b1;
    tick();
    check("rst_issue", dut_obs(), '0);
    rst = 1'b0;
    tick();
    check("rst_data_first", dut_obs(), exp_obs(0, 1, 1, 0, 1));
    set_in(0, 0, 0, 0, 1);
    tick();
    check("rst_data_done", dut_obs(), exp_obs(0, 0, 0, 0, 1));

    // with both pending at reset release, PRP wins the first tie
    set_in(1, 1, 0, 0, 0);
    rst = 1'b1;
    tick();
    check("rst_both", dut_obs(), '0);
    rst = 1'b0;
    tick();
    check("rst_prp_first", dut_obs(), exp_obs(1, 0, 1, 0, 0));
    $display("reset sequences: DATA alone granted, PRP wins tie");

    // randomized traffic against the model
    set_in(0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_busy = 0; m_last = 1; m_uf = 0; m_tx_req = 0;
    m_tag = '0; m_len = '0; m_addr = '0;
    for (int s = 0; s < 2; s++) begin
      m_cnt[s] = 0; m_ack[s] = 0; s_req[s] = 1'b0; s_hold[s] = 0;
      s_tag[s] = '0; s_len[s] = '0; s_addr[s] = '0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic c0, c1, ta;
      for (int s = 0; s < 2; s++) begin
        if (s_req[s] && m_ack[s] != 0) begin
          if ($urandom_range(1, 0) == 1) s_hold[s] = 1;
          else s_req[s] = 1'b0;
        end else if (s_hold[s] != 0) begin
          s_hold[s] = 0;
          s_req[s]  = 1'b0;
        end else if (!s_req[s] && $urandom_range(2, 0) == 0) begin
          s_req[s]  = 1'b1;
          s_tag[s]  = 8'($urandom);
          s_len[s]  = 11'($urandom);
          s_addr[s] = 46'({$urandom, $urandom});
        end
      end
      c0 = (m_cnt[0] > 0 && $urandom_range(3, 0) == 0) || $urandom_range(149, 0) == 0;
      c1 = (m_cnt[1] > 0 && $urandom_range(3, 0) == 0) || $urandom_range(149, 0) == 0;
      ta = (m_tx_req != 0) && $urandom_range(2, 0) == 0;
      prp_req  = s_req[0]; prp_tag  = s_tag[0]; prp_len  = s_len[0]; prp_addr  = s_addr[0];
      data_req = s_req[1]; data_tag = s_tag[1]; data_len = s_len[1]; data_addr = s_addr[1];
      prp_cpl = c0; data_cpl = c1; tx_ack = ta;
      model_step(c0, c1, ta);
      tick();
      check($sformatf("rand%0d", cyc), dut_obs(),
            {m_ack[0] != 0, m_ack[1] != 0, m_tx_req != 0, m_tag, m_len, m_addr, m_uf != 0});
      if (m_ack[0] != 0 || m_ack[1] != 0)
        $display("rand grant cyc=%0d src=%0d tag=%h len=%h addr=%h",
                 cyc, m_last, m_tag, m_len, m_addr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
